// File: rtl/frame_port_arbiter_if.sv
// Bundle of the two requester ports and the frame-buffer read port.
// master = requesters plus memory, slave = arbiter.
interface frame_port_arbiter_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              last0;
  logic              last1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_pixel;
  logic              busy;

  modport master (
    output req0, req1, addr0, addr1, last0, last1, frame_pixel,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, frame_addr, busy
  );

  modport slave (
    input  req0, req1, addr0, addr1, last0, last1, frame_pixel,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, frame_addr, busy
  );
endinterface

// File: rtl/frame_port_arbiter.sv
// Round-robin, burst-locked arbiter sharing one frame-buffer read port between
// two scan engines; read data is routed back by an owner tag through the latency pipe.
module frame_port_arbiter #(
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 320
) (
  input  logic                 clk25,
  input  logic                 rst_n,
  frame_port_arbiter_if.slave  bus
);
  localparam int unsigned     BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]   BCNT_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_served_q, last_served_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [ADDR_W-1:0]   frame_addr_q, frame_addr_d;
  logic [RD_LAT-1:0]   vld_q, tag_q;
  logic                rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;

  logic                acc, acc_tag;
  logic                cur, cur_req, cur_last, oth_req;
  logic [ADDR_W-1:0]   cur_addr;
  logic                pipe_vld, pipe_tag;

  // Both OWN states share one body, selected by the current owner index.
  assign cur      = (state_q == OWN1);
  assign cur_req  = cur ? bus.req1  : bus.req0;
  assign cur_last = cur ? bus.last1 : bus.last0;
  assign oth_req  = cur ? bus.req0  : bus.req1;
  assign cur_addr = cur ? bus.addr1 : bus.addr0;

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    bcnt_d        = bcnt_q;
    frame_addr_d  = frame_addr_q;
    acc           = 1'b0;
    acc_tag       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) state_d = last_served_q ? OWN0 : OWN1;
        else if (bus.req0)        state_d = OWN0;
        else if (bus.req1)        state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (cur_req) begin
          acc          = 1'b1;
          acc_tag      = cur;
          frame_addr_d = cur_addr;
          bcnt_d       = bcnt_q + 1'b1;
        end
        if (!cur_req || cur_last || (bcnt_q == BCNT_LAST)) begin
          last_served_d = cur;
          bcnt_d        = '0;
          if (oth_req) state_d = cur ? OWN0 : OWN1;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pipe_vld = vld_q[RD_LAT-1];
  assign pipe_tag = tag_q[RD_LAT-1];

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      bcnt_q        <= '0;
      frame_addr_q  <= '0;
      vld_q         <= '0;
      tag_q         <= '0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      bcnt_q        <= bcnt_d;
      frame_addr_q  <= frame_addr_d;
      vld_q[0]      <= acc;
      tag_q[0]      <= acc_tag;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      rvalid0_q <= pipe_vld && !pipe_tag;
      rvalid1_q <= pipe_vld &&  pipe_tag;
      if (pipe_vld && !pipe_tag) rdata0_q <= bus.frame_pixel;
      if (pipe_vld &&  pipe_tag) rdata1_q <= bus.frame_pixel;
    end
  end

  assign bus.gnt0       = (state_q == OWN0);
  assign bus.gnt1       = (state_q == OWN1);
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_addr = frame_addr_q;
  assign bus.rvalid0    = rvalid0_q;
  assign bus.rvalid1    = rvalid1_q;
  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;
endmodule
